systema_avm_cmd_master: RTL
===========================

# systema_avm_cmd_master

Single-outstanding Avalon-MM master that turns a simple valid/ready command stream into Avalon read/write transfers on the systema interconnect. It drives the same s1-style 32-bit slaves (PIO output registers and similar) from control logic in place of the processor. It honours waitrequest and readdatavalid, and returns a one-cycle response per command. A timeout guards against hung slaves.

## Interface
Parameters:
- ADDR_W, 2, Avalon word-address width.
- TIMEOUT, 255, maximum cycles spent in any bus state before the command is aborted with error; legal range 2..65535.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_address  in  ADDR_W  target word address.
- cmd_writedata  in  32  write data; ignored for reads.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_error  out  1  qualifies rsp_valid; 1 = timeout abort.
- rsp_readdata  out  32  read data; 0 for writes and errors.
- avm_address  out  ADDR_W  Avalon address.
- avm_read  out  1  Avalon read request.
- avm_write  out  1  Avalon write request.
- avm_writedata  out  32  Avalon write data.
- avm_byteenable  out  4  constant 4'hF.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  slave read data.
- avm_readdatavalid  in  1  read data qualifier; read latency at least 1 cycle after acceptance.

## Operation
- FSM states: IDLE, WRITE, READ, RDWAIT, RESP. Reset state is IDLE.
- IDLE:
  - cmd_ready = 1.
  - When cmd_valid is high, latch address, data and direction, then go to WRITE or READ.
- WRITE:
  - avm_write = 1 with the latched address and data held stable.
  - When avm_waitrequest = 0, go to RESP with no error.
- READ:
  - avm_read = 1.
  - When avm_waitrequest = 0, go to RDWAIT.
- RDWAIT:
  - No request is asserted.
  - On avm_readdatavalid = 1, capture avm_readdata into rsp_readdata and go to RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then go to IDLE.
  - There is no response backpressure.
- Timeout:
  - The counter clears on every state entry and increments each cycle in WRITE, READ and RDWAIT.
  - When the counter reaches TIMEOUT-1 and the completion condition is still false that cycle, go to RESP with rsp_error = 1 and rsp_readdata = 0.
  - avm_read/avm_write deassert on the abort. This is the documented fault-recovery deviation from the Avalon hold rule.
- Completion and timeout in the same cycle: completion wins, no error.
- avm_readdatavalid outside RDWAIT (e.g. a late beat after an abort) is ignored and never produces a response.
- rsp_readdata and rsp_error hold their values until the next RESP.
- avm_address and avm_writedata hold their last latched values when idle.

## Timing
- Reset values:
  - state IDLE, cmd_ready 1.
  - rsp_valid 0, rsp_error 0, rsp_readdata 0.
  - avm_read 0, avm_write 0, avm_address 0, avm_writedata 0.
- All outputs are registered or decoded from the state register. No combinational path from avm_* inputs to avm_* outputs.
- Command accepted at edge E0 → request asserted in the cycle after E0.
- Write, no wait: rsp_valid in cycle 2 after acceptance. Each waitrequest cycle adds 1.
- Read, no wait, latency L: rsp_valid in cycle 2+L after acceptance.
- cmd_ready returns high the cycle after RESP. Back-to-back throughput is one write per 3 cycles.
- Reset asserted mid-transfer: immediate return to IDLE, all outputs to reset values, no response emitted.

## Structure
- Shared include systema_avm_defs.vh holds:
  - state encodings, 3-bit localparams S_IDLE..S_RESP;
  - AVM_BE_ALL = 4'hF;
  - the timeout counter width rule, ceil(log2(TIMEOUT+1)).
- One natural sub-module, systema_avm_timeout: clear, enable, terminal-count flag, parameterised by TIMEOUT.
- Top level holds the FSM, command latch and response registers.

## Test plan
- Write with waitrequest 0: cmd write addr 0 data 0x000000A5, driving a PIO-style register slave → avm_write for exactly 1 cycle; rsp_valid 2 cycles after accept with rsp_error 0; slave out_port = 0xA5.
- Read with 3 waitrequest cycles, latency 2, slave data 0x12345678 → avm_read held 4 cycles with stable address; rsp_readdata = 0x12345678; rsp_valid 7 cycles after accept.
- Read timeout: TIMEOUT = 8, readdatavalid never arrives → rsp_valid with rsp_error 1 and rsp_readdata 0. A late readdatavalid two cycles later produces no second response.
- Waitrequest stuck at 1 on a write, TIMEOUT = 8 → avm_write drops after 8 cycles; error response; next command accepted normally.
- Completion on the terminal cycle: waitrequest falls exactly at count TIMEOUT-1 → rsp_error 0.
- reset_n pulsed low while in RDWAIT → outputs at reset values on the same edge, no rsp_valid; cmd_ready 1 after release.

Source files
------------

// File: rtl/systema_avm_cmd_master_pkg.sv
// Shared definitions for the systema Avalon-MM command master: state encoding,
// byte-enable constant and the timeout counter width rule.
package systema_avm_cmd_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_READ   = 3'd2,
    S_RDWAIT = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  localparam logic [3:0] AVM_BE_ALL = 4'hF;

  // Counter must be able to represent TIMEOUT itself.
  function automatic int tmo_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/systema_avm_cmd_master_timeout.sv
// Per-state cycle counter for the command master; flags the last cycle a bus
// state may occupy before the command is aborted.
module systema_avm_cmd_master_timeout
  import systema_avm_cmd_master_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam int CW = tmo_width(TIMEOUT);
  localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Saturates at the terminal count so a stalled state never wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != TC)) begin
      r_count <= r_count + CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_terminal = (r_count == TC);

endmodule

// File: rtl/systema_avm_cmd_master.sv
// Single-outstanding Avalon-MM master: one valid/ready command becomes one
// Avalon read or write, answered by a one-cycle response or a timeout error.
module systema_avm_cmd_master
  import systema_avm_cmd_master_pkg::*;
#(
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [31:0]       cmd_writedata,
  output logic              rsp_valid,
  output logic              rsp_error,
  output logic [31:0]       rsp_readdata,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  state_t              r_state;
  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic                r_rsp_error;
  logic [31:0]         r_rsp_readdata;
  logic [ADDR_W-1:0]   r_avm_address;
  logic                r_avm_read;
  logic                r_avm_write;
  logic [31:0]         r_avm_writedata;

  logic                w_tmo_clear;
  logic                w_tmo_enable;
  logic                w_tmo_terminal;

  // Counter runs only in bus states and restarts on every entry into one.
  always_comb begin
    w_tmo_clear  = 1'b0;
    w_tmo_enable = 1'b0;
    case (r_state)
      S_WRITE: begin
        w_tmo_enable = 1'b1;
      end
      S_READ: begin
        w_tmo_enable = 1'b1;
        w_tmo_clear  = ~avm_waitrequest;
      end
      S_RDWAIT: begin
        w_tmo_enable = 1'b1;
      end
      default: begin
        w_tmo_clear = 1'b1;
      end
    endcase
  end

  systema_avm_cmd_master_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk      (clk),
    .i_rst_n    (reset_n),
    .i_clear    (w_tmo_clear),
    .i_enable   (w_tmo_enable),
    .o_terminal (w_tmo_terminal)
  );

  // Command FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_cmd_ready     <= 1'b1;
      r_rsp_valid     <= 1'b0;
      r_rsp_error     <= 1'b0;
      r_rsp_readdata  <= 32'd0;
      r_avm_address   <= '0;
      r_avm_read      <= 1'b0;
      r_avm_write     <= 1'b0;
      r_avm_writedata <= 32'd0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_avm_address   <= cmd_address;
            r_avm_writedata <= cmd_writedata;
            r_cmd_ready     <= 1'b0;
            if (cmd_write) begin
              r_state     <= S_WRITE;
              r_avm_write <= 1'b1;
            end else begin
              r_state    <= S_READ;
              r_avm_read <= 1'b1;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        S_WRITE: begin
          if (!avm_waitrequest) begin
            r_state        <= S_RESP;
            r_avm_write    <= 1'b0;
            r_rsp_valid    <= 1'b1;
            r_rsp_error    <= 1'b0;
            r_rsp_readdata <= 32'd0;
          end else if (w_tmo_terminal) begin
            r_state        <= S_RESP;
            r_avm_write    <= 1'b0;
            r_rsp_valid    <= 1'b1;
            r_rsp_error    <= 1'b1;
            r_rsp_readdata <= 32'd0;
          end else begin
            r_state <= S_WRITE;
          end
        end
        S_READ: begin
          if (!avm_waitrequest) begin
            r_state    <= S_RDWAIT;
            r_avm_read <= 1'b0;
          end else if (w_tmo_terminal) begin
            // Abort drops the request even though the slave is still stalling.
            r_state        <= S_RESP;
            r_avm_read     <= 1'b0;
            r_rsp_valid    <= 1'b1;
            r_rsp_error    <= 1'b1;
            r_rsp_readdata <= 32'd0;
          end else begin
            r_state <= S_READ;
          end
        end
        S_RDWAIT: begin
          if (avm_readdatavalid) begin
            r_state        <= S_RESP;
            r_rsp_valid    <= 1'b1;
            r_rsp_error    <= 1'b0;
            r_rsp_readdata <= avm_readdata;
          end else if (w_tmo_terminal) begin
            r_state        <= S_RESP;
            r_rsp_valid    <= 1'b1;
            r_rsp_error    <= 1'b1;
            r_rsp_readdata <= 32'd0;
          end else begin
            r_state <= S_RDWAIT;
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_avm_read  <= 1'b0;
          r_avm_write <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready      = r_cmd_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_error      = r_rsp_error;
  assign rsp_readdata   = r_rsp_readdata;
  assign avm_address    = r_avm_address;
  assign avm_read       = r_avm_read;
  assign avm_write      = r_avm_write;
  assign avm_writedata  = r_avm_writedata;
  assign avm_byteenable = AVM_BE_ALL;

endmodule
